timer_host_ctrl: RTL and testbench

//  Avalon-MM master that drives the 16-bit-bus interval-timer slave: programs period and control,

---
 rtl/timer_host_pkg.sv | 46 ++++
 rtl/timer_host_ctrl_if.sv | 28 ++
 rtl/timer_host_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_timer_host_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_host_pkg.sv
// Shared constants for the interval-timer host controller: slave register map,
// control-register bit positions and the controller FSM encoding.
package timer_host_pkg;

  // Slave register addresses (16-bit registers)
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control register bit indices
  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  typedef enum logic [3:0] {
    StIdle,
    StWrPl,
    StWrPh,
    StWrCtrl,
    StRun,
    StClrSt,
    StWrSnap,
    StRdSl,
    StRdSlCap,
    StRdSh,
    StRdShCap,
    StWrStop
  } state_e;

  // Assemble a control-register write value
  function automatic logic [15:0] ctrl_word(input logic stop_b, input logic start_b,
                                            input logic cont_b, input logic ito_b);
    logic [15:0] w;
    w             = '0;
    w[CTRL_STOP]  = stop_b;
    w[CTRL_START] = start_b;
    w[CTRL_CONT]  = cont_b;
    w[CTRL_ITO]   = ito_b;
    return w;
  endfunction

endpackage

// File: rtl/timer_host_ctrl_if.sv
// Avalon-MM bus between the host controller (master) and the interval timer (slave),
// plus the timer interrupt line.
interface timer_host_ctrl_if;
  logic [2:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        timer_irq;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata,
    input  timer_irq
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata,
    output timer_irq
  );
endinterface

// File: rtl/timer_host_ctrl.sv
// Avalon-MM master that programs the interval timer, services its interrupt
// (status clear, snapshot, snapshot readback) and reports a tick per serviced irq.
module timer_host_ctrl
  import timer_host_pkg::*;
#(
  parameter bit          CONTINUOUS = 1'b1,
  parameter int unsigned MIN_PERIOD = 16,
  parameter int unsigned TICK_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [31:0]         cfg_period,
  timer_host_ctrl_if.master   avm,
  output logic                busy,
  output logic                tick,
  output logic [TICK_W-1:0]   tick_count,
  output logic [31:0]         snap_value,
  output logic                snap_valid
);

  localparam logic [31:0] MinPeriod = 32'(MIN_PERIOD);

  state_e              r_state;
  logic [2:0]          r_address;
  logic                r_chipselect;
  logic                r_write_n;
  logic [15:0]         r_writedata;
  logic [31:0]         r_period;
  logic [15:0]         r_snap_lo;
  logic                r_stop_pend;
  logic                r_busy;
  logic                r_tick;
  logic [TICK_W-1:0]   r_tick_count;
  logic [31:0]         r_snap_value;
  logic                r_snap_valid;

  logic [31:0]         w_period;
  logic                w_stop_any;

  // Clamp the requested period so a full service sequence fits between irqs
  assign w_period   = (cfg_period < MinPeriod) ? MinPeriod : cfg_period;
  // A stop arriving in the same cycle a RUN re-entry is decided counts as pending
  assign w_stop_any = r_stop_pend | stop;

  // Controller FSM; bus strobes and status outputs are set on state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_writedata  <= '0;
      r_period     <= '0;
      r_snap_lo    <= '0;
      r_stop_pend  <= 1'b0;
      r_busy       <= 1'b0;
      r_tick       <= 1'b0;
      r_tick_count <= '0;
      r_snap_value <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      // Bus is idle and pulses are low unless the entered state says otherwise
      r_chipselect <= 1'b0;
      r_write_n    <= 1'b1;
      r_tick       <= 1'b0;
      r_snap_valid <= 1'b0;

      if (stop && (r_state != StIdle) && (r_state != StRun)) begin
        r_stop_pend <= 1'b1;
      end

      unique case (r_state)
        StIdle: begin
          r_stop_pend <= 1'b0;
          if (start) begin
            r_period     <= w_period;
            r_tick_count <= '0;
            r_busy       <= 1'b1;
            r_state      <= StWrPl;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_address    <= ADDR_PERIOD_L;
            r_writedata  <= w_period[15:0];
          end
        end
        StWrPl: begin
          r_state      <= StWrPh;
          r_chipselect <= 1'b1;
          r_write_n    <= 1'b0;
          r_address    <= ADDR_PERIOD_H;
          r_writedata  <= r_period[31:16];
        end
        StWrPh: begin
          r_state      <= StWrCtrl;
          r_chipselect <= 1'b1;
          r_write_n    <= 1'b0;
          r_address    <= ADDR_CONTROL;
          r_writedata  <= ctrl_word(1'b0, 1'b1, CONTINUOUS, 1'b1);
        end
        StWrCtrl: begin
          if (w_stop_any) begin
            r_stop_pend  <= 1'b0;
            r_state      <= StWrStop;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_address    <= ADDR_CONTROL;
            r_writedata  <= ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
          end else begin
            r_state <= StRun;
          end
        end
        StRun: begin
          if (avm.timer_irq) begin
            // irq wins; a simultaneous stop is deferred to the end of service
            if (stop) begin
              r_stop_pend <= 1'b1;
            end
            r_state      <= StClrSt;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_address    <= ADDR_STATUS;
            r_writedata  <= '0;
          end else if (stop) begin
            r_state      <= StWrStop;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_address    <= ADDR_CONTROL;
            r_writedata  <= ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
          end
        end
        StClrSt: begin
          r_state      <= StWrSnap;
          r_chipselect <= 1'b1;
          r_write_n    <= 1'b0;
          r_address    <= ADDR_SNAP_L;
          r_writedata  <= '0;
        end
        StWrSnap: begin
          r_state      <= StRdSl;
          r_chipselect <= 1'b1;
          r_address    <= ADDR_SNAP_L;
        end
        StRdSl: begin
          r_state <= StRdSlCap;
        end
        StRdSlCap: begin
          r_snap_lo    <= avm.avm_readdata;
          r_state      <= StRdSh;
          r_chipselect <= 1'b1;
          r_address    <= ADDR_SNAP_H;
        end
        StRdSh: begin
          r_state <= StRdShCap;
        end
        StRdShCap: begin
          r_snap_value <= {avm.avm_readdata, r_snap_lo};
          r_snap_valid <= 1'b1;
          r_tick       <= 1'b1;
          r_tick_count <= r_tick_count + 1'b1;
          if (w_stop_any) begin
            r_stop_pend  <= 1'b0;
            r_state      <= StWrStop;
            r_chipselect <= 1'b1;
            r_write_n    <= 1'b0;
            r_address    <= ADDR_CONTROL;
            r_writedata  <= ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
          end else if (CONTINUOUS) begin
            r_state <= StRun;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StWrStop: begin
          r_stop_pend <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign avm.avm_address    = r_address;
  assign avm.avm_chipselect = r_chipselect;
  assign avm.avm_write_n    = r_write_n;
  assign avm.avm_writedata  = r_writedata;

  assign busy       = r_busy;
  assign tick       = r_tick;
  assign tick_count = r_tick_count;
  assign snap_value = r_snap_value;
  assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_timer_host_ctrl.sv
// Directed bench: two controllers (continuous, one-shot) each wired to a small
// interval-timer slave model.
module tb_timer_host_ctrl;
  import timer_host_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [1:0]  start;
  logic [1:0]  stop;
  logic [31:0] cfg_period [2];

  logic        busy_a  [2];
  logic        tick_a  [2];
  logic        sv_a    [2];
  logic [15:0] tc_a    [2];
  logic [31:0] snap_a  [2];
  logic        cs_a    [2];
  logic        wn_a    [2];
  logic [2:0]  addr_a  [2];
  logic [15:0] wd_a    [2];
  logic        irq_a   [2];
  logic        run_a   [2];
  int          ntick_a [2];

  for (genvar g = 0; g < 2; g++) begin : g_inst
    timer_host_ctrl_if bus ();

    logic [31:0] tm_period, tm_count, tm_snap;
    logic        tm_to, tm_run, tm_ito, tm_cont;
    logic [15:0] tm_rd;
    int          n_ticks;

    timer_host_ctrl #(
      .CONTINUOUS (g == 0),
      .MIN_PERIOD (16),
      .TICK_W     (16)
    ) dut (
      .clk        (clk),
      .reset      (rst),
      .start      (start[g]),
      .stop       (stop[g]),
      .cfg_period (cfg_period[g]),
      .avm        (bus),
      .busy       (busy_a[g]),
      .tick       (tick_a[g]),
      .tick_count (tc_a[g]),
      .snap_value (snap_a[g]),
      .snap_valid (sv_a[g])
    );

    assign bus.avm_readdata = tm_rd;
    assign bus.timer_irq    = tm_to & tm_ito;
    assign cs_a[g]    = bus.avm_chipselect;
    assign wn_a[g]    = bus.avm_write_n;
    assign addr_a[g]  = bus.avm_address;
    assign wd_a[g]    = bus.avm_writedata;
    assign irq_a[g]   = bus.timer_irq;
    assign run_a[g]   = tm_run;
    assign ntick_a[g] = n_ticks;

    // Interval timer model: period P times out every P+1 cycles
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        tm_period <= '0;
        tm_count  <= '0;
        tm_snap   <= '0;
        tm_to     <= 1'b0;
        tm_run    <= 1'b0;
        tm_ito    <= 1'b0;
        tm_cont   <= 1'b0;
        tm_rd     <= '0;
        n_ticks   <= 0;
      end else begin
        if (tick_a[g]) n_ticks <= n_ticks + 1;
        if (tm_run) begin
          if (tm_count == 0) begin
            tm_to <= 1'b1;
            if (tm_cont) tm_count <= tm_period;
            else tm_run <= 1'b0;
          end else begin
            tm_count <= tm_count - 1;
          end
        end
        if (bus.avm_chipselect && bus.avm_write_n) begin
          case (bus.avm_address)
            3'd0:    tm_rd <= {14'd0, tm_run, tm_to};
            3'd1:    tm_rd <= {14'd0, tm_cont, tm_ito};
            3'd2:    tm_rd <= tm_period[15:0];
            3'd3:    tm_rd <= tm_period[31:16];
            3'd4:    tm_rd <= tm_snap[15:0];
            3'd5:    tm_rd <= tm_snap[31:16];
            default: tm_rd <= '0;
          endcase
        end
        if (bus.avm_chipselect && !bus.avm_write_n) begin
          case (bus.avm_address)
            3'd0: tm_to <= 1'b0;
            3'd1: begin
              tm_ito  <= bus.avm_writedata[0];
              tm_cont <= bus.avm_writedata[1];
              if (bus.avm_writedata[3]) begin
                tm_run <= 1'b0;
              end else if (bus.avm_writedata[2]) begin
                tm_run   <= 1'b1;
                tm_count <= tm_period;
              end
            end
            3'd2:    tm_period[15:0]  <= bus.avm_writedata;
            3'd3:    tm_period[31:16] <= bus.avm_writedata;
            3'd4:    tm_snap <= tm_count;
            3'd5:    tm_snap <= tm_count;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int i, input string tag, input logic [2:0] a,
                        input logic [15:0] d);
    chk({tag, "_cs"}, 32'(cs_a[i]), 32'd1);
    chk({tag, "_wn"}, 32'(wn_a[i]), 32'd0);
    chk({tag, "_addr"}, 32'(addr_a[i]), 32'(a));
    chk({tag, "_data"}, 32'(wd_a[i]), 32'(d));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i, input logic [31:0] p);
    cfg_period[i] = p;
    start[i] = 1'b1;
    step(1);
    start[i] = 1'b0;
  endtask

  task automatic pulse_stop(input int i);
    stop[i] = 1'b1;
    step(1);
    stop[i] = 1'b0;
  endtask

  task automatic wait_tick(input int i, input string tag, output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      step(1);
      if (tick_a[i]) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_tick_seen"}, 32'(at >= 0), 32'd1);
  endtask

  task automatic wait_irq(input int i, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      step(1);
      if (irq_a[i]) begin
        seen = 1;
        break;
      end
    end
    chk({tag, "_irq_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1, t2, t3, n;
    rst = 1'b1;
    start = '0;
    stop = '0;
    cfg_period[0] = '0;
    cfg_period[1] = '0;
    #12;
    chk("rst_cs", 32'(cs_a[0]), 32'd0);
    chk("rst_wn", 32'(wn_a[0]), 32'd1);
    chk("rst_addr", 32'(addr_a[0]), 32'd0);
    chk("rst_wd", 32'(wd_a[0]), 32'd0);
    chk("rst_busy", 32'(busy_a[0]), 32'd0);
    chk("rst_tick", 32'(tick_a[0]), 32'd0);
    chk("rst_sv", 32'(sv_a[0]), 32'd0);
    chk("rst_tc", 32'(tc_a[0]), 32'd0);
    chk("rst_snap", snap_a[0], 32'd0);
    rst = 1'b0;
    step(1);

    // Programming sequence for a 32-bit period, then stop from RUN
    pulse_start(0, 32'h0001_0020);
    chk_wr(0, "pg_pl", ADDR_PERIOD_L, 16'h0020);
    chk("pg_busy", 32'(busy_a[0]), 32'd1);
    step(1);
    chk_wr(0, "pg_ph", ADDR_PERIOD_H, 16'h0001);
    step(1);
    chk_wr(0, "pg_ctrl", ADDR_CONTROL, 16'h0007);
    step(1);
    chk("pg_run_cs", 32'(cs_a[0]), 32'd0);
    chk("pg_tm_run", 32'(run_a[0]), 32'd1);
    pulse_stop(0);
    chk_wr(0, "pg_stop", ADDR_CONTROL, 16'h0008);
    step(1);
    chk("pg_idle", 32'(busy_a[0]), 32'd0);
    chk("pg_tm_stopped", 32'(run_a[0]), 32'd0);

    // Continuous, period 100: ticks every 101 cycles
    pulse_start(0, 32'd100);
    step(3);
    wait_tick(0, "c1", t1);
    chk("c1_count", 32'(tc_a[0]), 32'd1);
    chk("c1_sv", 32'(sv_a[0]), 32'd1);
    chk("c1_snap_le", 32'(snap_a[0] <= 32'd100), 32'd1);
    wait_tick(0, "c2", t2);
    chk("c2_interval", 32'(t2 - t1), 32'd101);
    chk("c2_count", 32'(tc_a[0]), 32'd2);
    wait_tick(0, "c3", t3);
    chk("c3_interval", 32'(t3 - t2), 32'd101);
    chk("c3_count", 32'(tc_a[0]), 32'd3);
    chk("c3_snap_le", 32'(snap_a[0] <= 32'd100), 32'd1);
    pulse_stop(0);
    chk_wr(0, "c_stop", ADDR_CONTROL, 16'h0008);
    step(1);
    chk("c_idle", 32'(busy_a[0]), 32'd0);

    // One-shot, period 50
    pulse_start(1, 32'd50);
    step(2);
    chk_wr(1, "os_ctrl", ADDR_CONTROL, 16'h0005);
    wait_tick(1, "os", t1);
    chk("os_count", 32'(tc_a[1]), 32'd1);
    chk("os_busy", 32'(busy_a[1]), 32'd0);
    step(2);
    chk("os_tm_stopped", 32'(run_a[1]), 32'd0);
    n = ntick_a[1];
    step(150);
    chk("os_no_more", 32'(ntick_a[1]), 32'(n));

    // Stop during WR_PH: control write still issued, then stop write
    pulse_start(0, 32'd100);
    step(1);
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    chk_wr(0, "sp_ctrl", ADDR_CONTROL, 16'h0007);
    step(1);
    chk_wr(0, "sp_stop", ADDR_CONTROL, 16'h0008);
    step(1);
    chk("sp_idle", 32'(busy_a[0]), 32'd0);
    n = ntick_a[0];
    step(250);
    chk("sp_no_ticks", 32'(ntick_a[0]), 32'(n));
    chk("sp_tm_stopped", 32'(run_a[0]), 32'd0);

    // Period clamp, then irq and stop in the same RUN cycle
    pulse_start(0, 32'd3);
    chk_wr(0, "cl_pl", ADDR_PERIOD_L, 16'h0010);
    step(1);
    chk_wr(0, "cl_ph", ADDR_PERIOD_H, 16'h0000);
    step(2);
    wait_irq(0, "bo");
    stop[0] = 1'b1;
    step(1);
    stop[0] = 1'b0;
    chk_wr(0, "bo_clr", ADDR_STATUS, 16'h0000);
    wait_tick(0, "bo", t1);
    chk("bo_count", 32'(tc_a[0]), 32'd1);
    chk_wr(0, "bo_stop", ADDR_CONTROL, 16'h0008);
    step(1);
    chk("bo_idle", 32'(busy_a[0]), 32'd0);

    // Reset asserted while in RD_SL, then a clean restart
    pulse_start(0, 32'd16);
    step(3);
    wait_tick(0, "rs", t1);
    chk("rs_count", 32'(tc_a[0]), 32'd1);
    wait_irq(0, "rs");
    step(3);
    chk("rs_rdsl_cs", 32'(cs_a[0]), 32'd1);
    chk("rs_rdsl_wn", 32'(wn_a[0]), 32'd1);
    chk("rs_rdsl_addr", 32'(addr_a[0]), 32'(ADDR_SNAP_L));
    rst = 1'b1;
    #1;
    chk("rs_cs", 32'(cs_a[0]), 32'd0);
    chk("rs_wn", 32'(wn_a[0]), 32'd1);
    chk("rs_addr", 32'(addr_a[0]), 32'd0);
    chk("rs_busy", 32'(busy_a[0]), 32'd0);
    chk("rs_tc", 32'(tc_a[0]), 32'd0);
    rst = 1'b0;
    step(1);
    pulse_start(0, 32'd20);
    chk_wr(0, "re_pl", ADDR_PERIOD_L, 16'd20);
    step(3);
    wait_tick(0, "re", t1);
    chk("re_count", 32'(tc_a[0]), 32'd1);
    chk("re_snap_le", 32'(snap_a[0] <= 32'd20), 32'd1);
    pulse_stop(0);
    step(1);
    chk("re_idle", 32'(busy_a[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
